// File: rtl/rst_seq_sync.sv
// ---------------------------------------------------------------------------
// rst_seq_sync
//   Two-flop synchronizer for a single asynchronous level, reset to 0.
//   Used to bring pll_lock into the clk domain ahead of the reset sequencer.
//
// Ports
//   clk  in   sampling clock
//   rst  in   asynchronous active-high reset (both flops clear to 0)
//   d    in   asynchronous input level
//   q    out  synchronized level, 2 clk edges behind d
// ---------------------------------------------------------------------------
module rst_seq_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq
//   Multi-domain reset sequencer. After PLL lock it releases N_STAGES reset
//   domains one at a time, each after a hold period and only once the
//   previous domain reports ready. Lock loss or a software request reasserts
//   every domain in one edge; a missing ready handshake parks the block in a
//   sticky FAULT state until software asks for a re-run.
//
// Parameters
//   N_STAGES      number of sequenced domains (2..8)
//   HOLD_CYCLES   cycles a domain stays in reset before release (1..255)
//   TIMEOUT_LOG2  ready timeout is 2^TIMEOUT_LOG2 cycles (4..24)
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   pll_lock     in   PLL lock, asynchronous (synchronized internally)
//   sw_rst_req   in   single-cycle request to re-run the sequence
//   stage_ready  in   per-domain ready, level-sensitive
//   stage_rst    out  per-domain active-high reset (registered)
//   stage_idx    out  index of the domain being brought up (registered)
//   sys_ready    out  high only once every domain is up (registered)
//   fault        out  sticky ready-timeout flag (registered)
// ---------------------------------------------------------------------------
module rst_seq #(
  parameter int N_STAGES     = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int TIMEOUT_LOG2 = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pll_lock,
  input  logic                        sw_rst_req,
  input  logic [N_STAGES-1:0]         stage_ready,
  output logic [N_STAGES-1:0]         stage_rst,
  output logic [$clog2(N_STAGES)-1:0] stage_idx,
  output logic                        sys_ready,
  output logic                        fault
);

  localparam int IDX_W = $clog2(N_STAGES);

  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(N_STAGES - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE   = IDX_W'(1);
  localparam logic [7:0]              HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]              HOLD_ONE  = 8'd1;
  localparam logic [TIMEOUT_LOG2-1:0] TO_MAX    = '1;
  localparam logic [TIMEOUT_LOG2-1:0] TO_ONE    = TIMEOUT_LOG2'(1);
  localparam logic [N_STAGES-1:0]     RST_ALL   = '1;
  localparam logic [N_STAGES-1:0]     RST_ONE   = N_STAGES'(1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                hold_cnt_q, hold_cnt_d;
  logic [TIMEOUT_LOG2-1:0]   to_cnt_q, to_cnt_d;
  logic [N_STAGES-1:0]       stage_rst_q, stage_rst_d;
  logic [IDX_W-1:0]          stage_idx_q, stage_idx_d;
  logic                      sys_ready_q, sys_ready_d;
  logic                      fault_q, fault_d;

  logic lock_s;
  logic abort;
  logic rdy_cur;
  logic hold_done;
  logic to_done;
  logic last_stage;

  rst_seq_sync u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Lock loss and the software request share one abort path; lock loss is
  // listed first only to document priority, the resulting action is identical.
  assign abort      = !lock_s || sw_rst_req;
  assign rdy_cur    = stage_ready[stage_idx_q];
  assign hold_done  = (hold_cnt_q == 8'd0);
  assign to_done    = (to_cnt_q == TO_MAX);
  assign last_stage = (stage_idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT_LOCK;
      hold_cnt_q  <= 8'd0;
      to_cnt_q    <= '0;
      stage_rst_q <= RST_ALL;
      stage_idx_q <= '0;
      sys_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stage_rst_q <= stage_rst_d;
      stage_idx_q <= stage_idx_d;
      sys_ready_q <= sys_ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT_LOCK: if (lock_s) state_d = S_HOLD;
      S_HOLD: begin
        if (abort)          state_d = S_WAIT_LOCK;
        else if (hold_done) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (abort)        state_d = S_WAIT_LOCK;
        else if (to_done) state_d = S_FAULT;
        else if (rdy_cur) state_d = last_stage ? S_RUN : S_HOLD;
      end
      S_RUN:   if (abort)      state_d = S_WAIT_LOCK;
      S_FAULT: if (sw_rst_req) state_d = S_WAIT_LOCK;
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  // Counter and registered-output logic
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    stage_rst_d = stage_rst_q;
    stage_idx_d = stage_idx_q;
    sys_ready_d = sys_ready_q;
    fault_d     = fault_q;
    unique case (state_q)
      S_WAIT_LOCK: begin
        stage_rst_d = RST_ALL;
        stage_idx_d = '0;
        sys_ready_d = 1'b0;
        if (lock_s) hold_cnt_d = HOLD_LOAD;
      end
      S_HOLD: begin
        if (abort) begin
          stage_rst_d = RST_ALL;
          stage_idx_d = '0;
          sys_ready_d = 1'b0;
        end else if (hold_done) begin
          // Only the current stage's bit is cleared, so releases follow index order.
          stage_rst_d = stage_rst_q & ~(RST_ONE << stage_idx_q);
          to_cnt_d    = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
      end
      S_WAIT_RDY: begin
        if (abort) begin
          stage_rst_d = RST_ALL;
          stage_idx_d = '0;
          sys_ready_d = 1'b0;
        end else if (to_done) begin
          stage_rst_d = RST_ALL;
          sys_ready_d = 1'b0;
          fault_d     = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
          if (rdy_cur) begin
            if (last_stage) begin
              sys_ready_d = 1'b1;
            end else begin
              stage_idx_d = stage_idx_q + IDX_ONE;
              hold_cnt_d  = HOLD_LOAD;
            end
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          stage_rst_d = RST_ALL;
          stage_idx_d = '0;
          sys_ready_d = 1'b0;
        end
      end
      S_FAULT: begin
        stage_rst_d = RST_ALL;
        sys_ready_d = 1'b0;
        if (sw_rst_req) begin
          fault_d     = 1'b0;
          stage_idx_d = '0;
        end
      end
      default: begin
        stage_rst_d = RST_ALL;
        stage_idx_d = '0;
        sys_ready_d = 1'b0;
      end
    endcase
  end

  assign stage_rst = stage_rst_q;
  assign stage_idx = stage_idx_q;
  assign sys_ready = sys_ready_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq
//   Directed bench for rst_seq. Two instances share clk and rst: one with
//   default parameters for bring-up, slow ready, lock loss, simultaneous
//   events and async reset; one with TIMEOUT_LOG2 = 4 for the fault path.
//   Edge numbers in comments count posedges after the stimulus change.
// ---------------------------------------------------------------------------
module tb_rst_seq;

  logic       clk;
  logic       rst;

  logic       pll_lock;
  logic       sw_rst_req;
  logic [2:0] stage_ready;
  logic [2:0] stage_rst;
  logic [1:0] stage_idx;
  logic       sys_ready;
  logic       fault;

  logic       t_pll_lock;
  logic       t_sw_rst_req;
  logic [2:0] t_stage_ready;
  logic [2:0] t_stage_rst;
  logic [1:0] t_stage_idx;
  logic       t_sys_ready;
  logic       t_fault;

  int checks = 0;
  int errors = 0;

  rst_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .pll_lock    (pll_lock),
    .sw_rst_req  (sw_rst_req),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .stage_idx   (stage_idx),
    .sys_ready   (sys_ready),
    .fault       (fault)
  );

  rst_seq #(.N_STAGES(3), .HOLD_CYCLES(16), .TIMEOUT_LOG2(4)) u_dut_to (
    .clk         (clk),
    .rst         (rst),
    .pll_lock    (t_pll_lock),
    .sw_rst_req  (t_sw_rst_req),
    .stage_ready (t_stage_ready),
    .stage_rst   (t_stage_rst),
    .stage_idx   (t_stage_idx),
    .sys_ready   (t_sys_ready),
    .fault       (t_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    pll_lock      = 1'b0;
    sw_rst_req    = 1'b0;
    stage_ready   = 3'b111;
    t_pll_lock    = 1'b0;
    t_sw_rst_req  = 1'b0;
    t_stage_ready = 3'b000;

    // Reset values
    #1;
    chk("rst_stage_rst", 32'(stage_rst), 32'h7);
    chk("rst_stage_idx", 32'(stage_idx), 32'h0);
    chk("rst_sys_ready", 32'(sys_ready), 32'h0);
    chk("rst_fault",     32'(fault),     32'h0);
    chk("rst_t_rst",     32'(t_stage_rst), 32'h7);
    tick(3);

    // Nominal bring-up: lock rises before edge 1
    @(negedge clk);
    rst      = 1'b0;
    pll_lock = 1'b1;
    tick(18);
    chk("nom_e18_rst", 32'(stage_rst), 32'h7);
    tick(1);
    chk("nom_e19_rst", 32'(stage_rst), 32'h6);
    tick(16);
    chk("nom_e35_rst", 32'(stage_rst), 32'h6);
    chk("nom_e35_idx", 32'(stage_idx), 32'h1);
    tick(1);
    chk("nom_e36_rst", 32'(stage_rst), 32'h4);
    tick(17);
    chk("nom_e53_rst", 32'(stage_rst), 32'h0);
    chk("nom_e53_sys", 32'(sys_ready), 32'h0);
    tick(1);
    chk("nom_e54_sys", 32'(sys_ready), 32'h1);
    chk("nom_e54_idx", 32'(stage_idx), 32'h2);

    // Lock loss in RUN: abort 3 edges after pll_lock falls
    pll_lock = 1'b0;
    tick(2);
    chk("ll_e2_sys", 32'(sys_ready), 32'h1);
    chk("ll_e2_rst", 32'(stage_rst), 32'h0);
    tick(1);
    chk("ll_e3_rst", 32'(stage_rst), 32'h7);
    chk("ll_e3_sys", 32'(sys_ready), 32'h0);
    chk("ll_e3_idx", 32'(stage_idx), 32'h0);

    // Lock returns, stage 1 slow: rerun timing matches nominal
    stage_ready = 3'b101;
    tick(4);
    @(negedge clk);
    pll_lock = 1'b1;
    tick(18);
    chk("re_e18_rst", 32'(stage_rst), 32'h7);
    tick(1);
    chk("re_e19_rst", 32'(stage_rst), 32'h6);
    tick(17);
    chk("re_e36_rst", 32'(stage_rst), 32'h4);
    tick(99);
    chk("slow_idx_hold", 32'(stage_idx), 32'h1);
    chk("slow_rst_hold", 32'(stage_rst), 32'h4);
    stage_ready = 3'b111;
    tick(1);
    chk("slow_k_idx", 32'(stage_idx), 32'h2);
    chk("slow_k_rst", 32'(stage_rst), 32'h4);
    tick(15);
    chk("slow_k15_rst", 32'(stage_rst), 32'h4);
    tick(1);
    chk("slow_k16_rst", 32'(stage_rst), 32'h0);
    tick(1);
    chk("slow_run_sys", 32'(sys_ready), 32'h1);

    // Software re-sequence from RUN
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sw_run_rst", 32'(stage_rst), 32'h7);
    chk("sw_run_sys", 32'(sys_ready), 32'h0);
    stage_ready = 3'b011;
    tick(17);
    chk("sim_a17_rst", 32'(stage_rst), 32'h6);
    tick(34);
    chk("sim_a51_rst", 32'(stage_rst), 32'h0);
    chk("sim_a51_idx", 32'(stage_idx), 32'h2);
    tick(3);
    chk("sim_wait_sys", 32'(sys_ready), 32'h0);

    // Simultaneous sw_rst_req and final-stage ready: abort wins
    sw_rst_req  = 1'b1;
    stage_ready = 3'b111;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sim_rst", 32'(stage_rst), 32'h7);
    chk("sim_sys", 32'(sys_ready), 32'h0);
    chk("sim_idx", 32'(stage_idx), 32'h0);
    tick(1);
    chk("sim_sys_next", 32'(sys_ready), 32'h0);

    // Async rst during HOLD of stage 1
    tick(19);
    chk("arst_pre_rst", 32'(stage_rst), 32'h6);
    chk("arst_pre_idx", 32'(stage_idx), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rst", 32'(stage_rst), 32'h7);
    chk("arst_idx", 32'(stage_idx), 32'h0);
    chk("arst_sys", 32'(sys_ready), 32'h0);
    chk("arst_fault", 32'(fault), 32'h0);
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    tick(18);
    chk("arst_e18_rst", 32'(stage_rst), 32'h7);
    tick(1);
    chk("arst_e19_rst", 32'(stage_rst), 32'h6);
    tick(35);
    chk("arst_e54_sys", 32'(sys_ready), 32'h1);
    chk("arst_e54_rst", 32'(stage_rst), 32'h0);

    // Timeout on stage 0 with TIMEOUT_LOG2 = 4
    @(negedge clk);
    t_pll_lock = 1'b1;
    tick(18);
    chk("to_e18_rst", 32'(t_stage_rst), 32'h7);
    tick(1);
    chk("to_e19_rst", 32'(t_stage_rst), 32'h6);
    tick(15);
    chk("to_e34_rst", 32'(t_stage_rst), 32'h6);
    chk("to_e34_fault", 32'(t_fault), 32'h0);
    tick(1);
    chk("to_e35_rst", 32'(t_stage_rst), 32'h7);
    chk("to_e35_fault", 32'(t_fault), 32'h1);
    chk("to_e35_sys", 32'(t_sys_ready), 32'h0);

    // Lock toggling does not leave FAULT
    t_pll_lock = 1'b0;
    tick(5);
    chk("to_lockoff_fault", 32'(t_fault), 32'h1);
    t_pll_lock = 1'b1;
    tick(5);
    chk("to_lockon_fault", 32'(t_fault), 32'h1);
    chk("to_lockon_rst", 32'(t_stage_rst), 32'h7);

    // sw_rst_req clears fault and the sequence restarts
    t_sw_rst_req = 1'b1;
    tick(1);
    t_sw_rst_req = 1'b0;
    chk("to_sw_fault", 32'(t_fault), 32'h0);
    chk("to_sw_rst", 32'(t_stage_rst), 32'h7);
    tick(16);
    chk("to_re16_rst", 32'(t_stage_rst), 32'h7);
    tick(1);
    chk("to_re17_rst", 32'(t_stage_rst), 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Multi-domain reset sequencer sitting directly behind the system clock/reset generator. After PLL lock it releases up to N_STAGES downstream reset domains (e.g. QPI memory controller, video, CPU) one at a time. Each stage waits for that domain's ready handshake before the next is released. A per-stage timeout, a software re-sequence request and PLL lock loss are all handled without glitching the reset outputs.

## Interface

Parameters:
- N_STAGES, 3, number of sequenced reset domains; legal range 2..8.
- HOLD_CYCLES, 16, clk cycles a domain stays in reset after the previous step completes; legal range 1..255.
- TIMEOUT_LOG2, 16, WAIT_RDY timeout is 2^TIMEOUT_LOG2 cycles; legal range 4..24.

Ports:
- clk, in, 1, sole clock (the 1x system clock).
- rst, in, 1, asynchronous, active-high reset.
- pll_lock, in, 1, PLL lock; asynchronous to clk; synchronized internally through 2 flops to give lock_s.
- sw_rst_req, in, 1, single-cycle request to re-run the full sequence; synchronous to clk.
- stage_ready, in, N_STAGES, per-domain ready; synchronous to clk; level-sensitive.
- stage_rst, out, N_STAGES, per-domain active-high reset; registered.
- stage_idx, out, $clog2(N_STAGES), index of the stage currently being brought up; registered.
- sys_ready, out, 1, high only in RUN; registered.
- fault, out, 1, sticky timeout flag; registered.

## Operation

- **Reset values:**
  - stage_rst = all ones.
  - stage_idx = 0.
  - sys_ready = 0.
  - fault = 0.
  - State = WAIT_LOCK.
  - Hold and timeout counters = 0.
  - Synchronizer flops = 0.
- **WAIT_LOCK:**
  - All stage_rst high and stage_idx = 0.
  - On lock_s = 1: load hold counter with HOLD_CYCLES-1, then go to HOLD.
- **HOLD:**
  - Hold counter decrements each cycle.
  - At 0: deassert stage_rst[stage_idx], clear the timeout counter, then go to WAIT_RDY.
- **WAIT_RDY:**
  - Timeout counter increments each cycle.
  - If stage_ready[stage_idx] = 1 and stage_idx = N_STAGES-1: go to RUN and set sys_ready = 1.
  - If stage_ready[stage_idx] = 1 and stage_idx < N_STAGES-1: increment stage_idx, reload the hold counter, then go to HOLD.
  - If the timeout counter reaches 2^TIMEOUT_LOG2-1 without ready: go to FAULT. This asserts all stage_rst and sets fault = 1.
  - Only stage_ready[stage_idx] is examined. Ready bits of other stages are ignored.
- **RUN:**
  - Released stages stay released.
  - stage_rst is all zeros.
- **FAULT:**
  - All stage_rst high; fault = 1 and sys_ready = 0.
  - Stays here regardless of lock_s.
  - Exits only on sw_rst_req, which clears fault and goes to WAIT_LOCK.
- **Abort conditions in HOLD, WAIT_RDY and RUN.** Priority order: lock loss > sw_rst_req > timeout > ready.
  - lock_s = 0 (lock loss): next edge asserts all stage_rst, clears sys_ready and stage_idx, then goes to WAIT_LOCK.
  - sw_rst_req: same action as lock loss.
- sw_rst_req in WAIT_LOCK is ignored.
- **Reset output rules:**
  - stage_rst bits only go high→low in stage order.
  - Any abort reasserts all bits in the same cycle.
  - No bit ever pulses low for less than one full cycle.
- Counter widths:
  - Hold counter: 8 bits.
  - Timeout counter: TIMEOUT_LOG2 bits; it does not wrap because it exits at all-ones.

## Timing

- lock_s follows pll_lock by 2 clk edges.
- HOLD is entered on the edge after lock_s is first sampled high.
- stage_rst[0] falls HOLD_CYCLES edges after entering HOLD. With defaults and pll_lock rising before edge 1:
  - lock_s is high after edge 2.
  - HOLD is entered at edge 3.
  - stage_rst[0] falls at edge 19.
- Ready is sampled at edge k. Then:
  - stage_idx increments at edge k.
  - stage_rst[stage_idx+1] falls at edge k+HOLD_CYCLES.
- Final-stage ready at edge k sets sys_ready high after edge k (1-cycle latency).
- Timeout: FAULT is entered exactly 2^TIMEOUT_LOG2 edges after WAIT_RDY is entered.
- Abort: all outputs take abort values 1 edge after lock_s = 0 or sw_rst_req is sampled. End-to-end from pll_lock falling, this is 3 edges.
- Asynchronous rst forces reset values immediately, mid-sequence included.

## Structure

- State encoding, counter widths and limits are localparams in the module. None are shared, so no package is needed.
- One sub-module: rst_seq_sync, a 2-flop synchronizer with async reset to 0, used for pll_lock.
- FSM, counters and output registers live in rst_seq.

## Test plan

- **Nominal bring-up** (defaults, all stage_ready tied high, pll_lock rises before edge 1): stage_rst steps 3'b111→110→100→000 at edges 19/36/53; sys_ready = 1 after edge 54.
- **Slow ready:** stage_ready[1] goes high 100 cycles after stage_rst[1] falls. Required: stage_idx holds at 1 throughout; stage_rst[2] falls HOLD_CYCLES edges after ready is sampled.
- **Timeout** (TIMEOUT_LOG2 = 4, stage_ready[0] held low): FAULT is entered 16 edges after stage_rst[0] falls. Required:
  - stage_rst = 3'b111 and fault = 1.
  - Toggling pll_lock has no effect.
  - A sw_rst_req pulse clears fault and the sequence restarts.
- **Lock loss in RUN:** pll_lock drops. Required: stage_rst = 3'b111 and sys_ready = 0 after 3 edges. When lock returns, the full sequence reruns with identical timing.
- **Simultaneous events:** sw_rst_req and stage_ready[2] in the same cycle of WAIT_RDY. Required: the abort wins, giving WAIT_LOCK, stage_rst = 3'b111 and sys_ready never high.
- **Async rst mid-HOLD** (asserted between clock edges): all outputs reach reset values without waiting for a clk edge; after release, bring-up matches the nominal case.
